mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
Multi-cycle control sequencer for the MIPS datapath, replacing single-cycle decode with a per-instruction state machine. It drives the shared memory port, IR/PC enables, register-file and data-memory write enables, ALU source and operation selects, and stalls on a memory ready handshake. It also counts retired instructions and flags illegal opcodes. It sits between the instruction register opcode field and the datapath muxes and enables.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
OP  in  6  opcode from instruction register (IR[31:26])
zero  in  1  ALU zero flag
mem_ready  in  1  memory completed access this cycle
mem_req  out  1  memory access request
IorD  out  1  memory address select: 0=PC, 1=ALUOut
IR_WE  out  1  instruction register load
PC_WE  out  1  PC write (unconditional or taken branch)
PC_src  out  2  00=ALU result, 01=ALUOut (branch), 10=jump target
Reg_WE  out  1  register file write
REG_Dst  out  1  1=rd, 0=rt
MEM_to_REG  out  1  1=MDR, 0=ALUOut
DM_WE  out  1  data memory write
ALU_srcA  out  1  0=PC, 1=rs
ALU_srcB  out  2  00=rt, 01=const 4, 10=signext imm, 11=signext imm<<2
ALU_OP  out  2  00=add, 01=sub, 10=funct-decoded
illegal  out  1  one-cycle pulse, unsupported opcode in DECODE
retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rst_n low): state=START, retired=0. All outputs are 0 in START.
- Outputs are decoded from the state register. FETCH, MEMRD and MEMWR also depend on mem_ready.
- START: all outputs 0; next state FETCH.
- FETCH: mem_req=1, IorD=0, ALU_srcA=0, ALU_srcB=01, ALU_OP=00, PC_src=00. IR_WE=PC_WE=mem_ready. Stay in FETCH while mem_ready=0, else go to DECODE.
- DECODE: ALU_srcA=0, ALU_srcB=11, ALU_OP=00 (branch target into ALUOut).
  - Next state by OP: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP.
  - Any other OP: illegal=1 for this cycle; next FETCH; retired unchanged.
- MEMADR: ALU_srcA=1, ALU_srcB=10, ALU_OP=00. Next: MEMRD if OP=100011, else MEMWR.
- MEMRD: mem_req=1, IorD=1. Hold until mem_ready, then MEMWB.
- MEMWB: Reg_WE=1, REG_Dst=0, MEM_to_REG=1. Retire; next FETCH.
- MEMWR: mem_req=1, IorD=1, DM_WE=mem_ready. Hold until mem_ready, then retire; next FETCH.
- EXEC: ALU_srcA=1, ALU_srcB=00, ALU_OP=10. Next ALUWB.
- ALUWB: Reg_WE=1, REG_Dst=1, MEM_to_REG=0. Retire; next FETCH.
- BRANCH: ALU_srcA=1, ALU_srcB=00, ALU_OP=01, PC_src=01, PC_WE=zero. Retire; next FETCH.
- ADDIEX: ALU_srcA=1, ALU_srcB=10, ALU_OP=00. Next ADDIWB.
- ADDIWB: Reg_WE=1, REG_Dst=0, MEM_to_REG=0. Retire; next FETCH.
- JUMP: PC_src=10, PC_WE=1. Retire; next FETCH.
- Retire: retired increments by 1 on the clock edge that leaves the final state. It wraps modulo 2^CNT_W with no saturation.
- Latencies with mem_ready=1 throughout:
  - lw: 5 cycles; R-type and addi: 4; sw: 4; beq and j: 3.
  - Each mem_ready=0 cycle adds one cycle in FETCH/MEMRD/MEMWR.
- Write enables (Reg_WE, DM_WE, IR_WE, PC_WE) are never asserted in START, or in any cycle where mem_ready gates them and mem_ready=0.
- Reset mid-instruction: immediate return to START and all outputs 0 (combinational via state). The partial instruction is not retired.
- Unused state encodings: next state START.

Decomposition:
- Package mc_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), state enum (START..JUMP, 4-bit), ALU_OP and ALU_srcB/PC_src encodings.
- Single module, no sub-module. The retire counter is inline (too small to split).

Test Plan:
- Reset asserted mid-MEMRD -> state START, all outputs 0, retired=0. After release: START then FETCH, mem_req=1.
- R-type (OP=000000), mem_ready=1 -> FETCH, DECODE, EXEC (ALU_OP=10), ALUWB (Reg_WE=1, REG_Dst=1); retired 0->1 after 4 cycles.
- lw with mem_ready low 2 cycles in FETCH and 3 in MEMRD:
  - total 10 cycles;
  - IR_WE pulses exactly once;
  - MEMWB has Reg_WE=1, MEM_to_REG=1;
  - retired +1.
- beq with zero=1 -> BRANCH PC_WE=1, PC_src=01. With zero=0 -> PC_WE=0. Both retire after 3 cycles.
- sw -> DM_WE high only in the MEMWR cycle with mem_ready=1; Reg_WE never high.
- OP=111111 -> illegal=1 in DECODE for one cycle, next FETCH, retired unchanged.
- j back-to-back 2^CNT_W times (CNT_W=4 in test) -> retired wraps 15->0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer:
// opcode values, FSM state encoding and datapath select encodings.
package mc_pkg;

  // Opcode field values (IR[31:26]) understood by the sequencer
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Sequencer states; encodings 13..15 are unused and recover to START
  typedef enum logic [3:0] {
    ST_START  = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_ALUWB  = 4'd8,
    ST_BRANCH = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11,
    ST_JUMP   = 4'd12
  } state_e;

  // ALU operation select
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-operand select
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // True for every opcode the sequencer has a path for
  function automatic logic op_is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer for the MIPS datapath. One pass through
// the state machine per instruction; outputs are decoded from the current
// state (plus mem_ready in the memory-access states) so that a reset
// forces every control line low immediately.
//
// state  | meaning
// -------+-----------------------------------------------------------
// START  | post-reset idle, all controls low
// FETCH  | read instruction at PC, PC+4 into PC when memory is ready
// DECODE | compute branch target into ALUOut, dispatch on opcode
// MEMADR | rs + signext(imm) effective address for lw/sw
// MEMRD  | data read at ALUOut, wait for memory
// MEMWB  | MDR into rt (lw retires)
// MEMWR  | data write at ALUOut, wait for memory (sw retires)
// EXEC   | R-type ALU operation on rs, rt
// ALUWB  | ALUOut into rd (R-type retires)
// BRANCH | rs - rt compare, load branch target on zero (beq retires)
// ADDIEX | rs + signext(imm)
// ADDIWB | ALUOut into rt (addi retires)
// JUMP   | load jump target (j retires)
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       OP,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             IorD,
  output logic             IR_WE,
  output logic             PC_WE,
  output logic [1:0]       PC_src,
  output logic             Reg_WE,
  output logic             REG_Dst,
  output logic             MEM_to_REG,
  output logic             DM_WE,
  output logic             ALU_srcA,
  output logic [1:0]       ALU_srcB,
  output logic [1:0]       ALU_OP,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  import mc_pkg::*;

  state_e           state_q, state_d;
  logic             retire_d;
  logic [CNT_W-1:0] retired_q;

  // Next-state selection and retire strobe on leaving an instruction's last state
  always_comb begin
    state_d  = state_q;
    retire_d = 1'b0;
    case (state_q)
      ST_START:  state_d = ST_FETCH;
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (OP)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_J:         state_d = ST_JUMP;
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: state_d = (OP == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  if (mem_ready) state_d = ST_MEMWB;
      ST_MEMWB: begin
        state_d  = ST_FETCH;
        retire_d = 1'b1;
      end
      ST_MEMWR: begin
        if (mem_ready) begin
          state_d  = ST_FETCH;
          retire_d = 1'b1;
        end
      end
      ST_EXEC:   state_d = ST_ALUWB;
      ST_ALUWB: begin
        state_d  = ST_FETCH;
        retire_d = 1'b1;
      end
      ST_BRANCH: begin
        state_d  = ST_FETCH;
        retire_d = 1'b1;
      end
      ST_ADDIEX: state_d = ST_ADDIWB;
      ST_ADDIWB: begin
        state_d  = ST_FETCH;
        retire_d = 1'b1;
      end
      ST_JUMP: begin
        state_d  = ST_FETCH;
        retire_d = 1'b1;
      end
      default:   state_d = ST_START;
    endcase
  end

  // State register and retired-instruction counter (wraps, no saturation)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_START;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire_d) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Datapath control decode; memory-gated enables follow mem_ready in the same cycle
  always_comb begin
    mem_req    = 1'b0;
    IorD       = 1'b0;
    IR_WE      = 1'b0;
    PC_WE      = 1'b0;
    PC_src     = PCSRC_ALU;
    Reg_WE     = 1'b0;
    REG_Dst    = 1'b0;
    MEM_to_REG = 1'b0;
    DM_WE      = 1'b0;
    ALU_srcA   = 1'b0;
    ALU_srcB   = SRCB_RT;
    ALU_OP     = ALUOP_ADD;
    illegal    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req  = 1'b1;
        ALU_srcB = SRCB_FOUR;
        IR_WE    = mem_ready;
        PC_WE    = mem_ready;
      end
      ST_DECODE: begin
        ALU_srcB = SRCB_IMM_SH;
        illegal  = !op_is_legal(OP);
      end
      ST_MEMADR: begin
        ALU_srcA = 1'b1;
        ALU_srcB = SRCB_IMM;
      end
      ST_MEMRD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
      end
      ST_MEMWB: begin
        Reg_WE     = 1'b1;
        MEM_to_REG = 1'b1;
      end
      ST_MEMWR: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
        DM_WE   = mem_ready;
      end
      ST_EXEC: begin
        ALU_srcA = 1'b1;
        ALU_OP   = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        Reg_WE  = 1'b1;
        REG_Dst = 1'b1;
      end
      ST_BRANCH: begin
        ALU_srcA = 1'b1;
        ALU_OP   = ALUOP_SUB;
        PC_src   = PCSRC_ALUOUT;
        PC_WE    = zero;
      end
      ST_ADDIEX: begin
        ALU_srcA = 1'b1;
        ALU_srcB = SRCB_IMM;
      end
      ST_ADDIWB: begin
        Reg_WE = 1'b1;
      end
      ST_JUMP: begin
        PC_src = PCSRC_JUMP;
        PC_WE  = 1'b1;
      end
      default: ;
    endcase
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: an instruction-level model (opcode -> list of phases,
// per-phase control table) is compared against the DUT every cycle, and
// directed instruction runs pin latency, pulse counts and counter wrap.
module tb_mc_ctrl;

  localparam int CNT_W = 4;

  localparam logic [5:0] I_RT   = 6'b000000;
  localparam logic [5:0] I_LW   = 6'b100011;
  localparam logic [5:0] I_SW   = 6'b101011;
  localparam logic [5:0] I_BEQ  = 6'b000100;
  localparam logic [5:0] I_ADDI = 6'b001000;
  localparam logic [5:0] I_J    = 6'b000010;
  localparam logic [5:0] I_BAD  = 6'b111111;

  localparam int P_START = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADR = 3,
                 P_MEMRD = 4, P_MEMWB = 5, P_MEMWR = 6, P_EXEC = 7,
                 P_ALUWB = 8, P_BRANCH = 9, P_ADDIEX = 10, P_ADDIWB = 11,
                 P_JUMP = 12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [5:0]       OP = '0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, IorD, IR_WE, PC_WE, Reg_WE, REG_Dst, MEM_to_REG;
  logic             DM_WE, ALU_srcA, illegal;
  logic [1:0]       PC_src, ALU_srcB, ALU_OP;
  logic [CNT_W-1:0] retired;

  mc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .OP(OP), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .IR_WE(IR_WE), .PC_WE(PC_WE),
    .PC_src(PC_src), .Reg_WE(Reg_WE), .REG_Dst(REG_Dst),
    .MEM_to_REG(MEM_to_REG), .DM_WE(DM_WE), .ALU_srcA(ALU_srcA),
    .ALU_srcB(ALU_srcB), .ALU_OP(ALU_OP), .illegal(illegal),
    .retired(retired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] dut_vec;
  assign dut_vec = {mem_req, IorD, IR_WE, PC_WE, PC_src, Reg_WE, REG_Dst,
                    MEM_to_REG, DM_WE, ALU_srcA, ALU_srcB, ALU_OP, illegal};

  // ---------------- model ----------------
  int m_ph = P_START;
  int route[$];
  int m_ret = 0;

  function automatic bit known_op(input logic [5:0] op);
    return op == I_RT || op == I_LW || op == I_SW || op == I_BEQ ||
           op == I_ADDI || op == I_J;
  endfunction

  function automatic logic [15:0] model_out(input int ph, input logic mr,
                                            input logic z, input logic [5:0] op);
    logic mreq, iord, irwe, pcwe, rwe, rdst, m2r, dmwe, srca, ill;
    logic [1:0] pcsrc, srcb, aluop;
    {mreq, iord, irwe, pcwe, rwe, rdst, m2r, dmwe, srca, ill} = '0;
    pcsrc = 2'b00; srcb = 2'b00; aluop = 2'b00;
    case (ph)
      P_FETCH:  begin mreq = 1; srcb = 2'b01; irwe = mr; pcwe = mr; end
      P_DECODE: begin srcb = 2'b11; ill = !known_op(op); end
      P_MEMADR: begin srca = 1; srcb = 2'b10; end
      P_MEMRD:  begin mreq = 1; iord = 1; end
      P_MEMWB:  begin rwe = 1; m2r = 1; end
      P_MEMWR:  begin mreq = 1; iord = 1; dmwe = mr; end
      P_EXEC:   begin srca = 1; aluop = 2'b10; end
      P_ALUWB:  begin rwe = 1; rdst = 1; end
      P_BRANCH: begin srca = 1; aluop = 2'b01; pcsrc = 2'b01; pcwe = z; end
      P_ADDIEX: begin srca = 1; srcb = 2'b10; end
      P_ADDIWB: begin rwe = 1; end
      P_JUMP:   begin pcsrc = 2'b10; pcwe = 1; end
      default: ;
    endcase
    return {mreq, iord, irwe, pcwe, pcsrc, rwe, rdst, m2r, dmwe, srca,
            srcb, aluop, ill};
  endfunction

  // Instruction-level progress: a phase list per opcode, memory phases stall
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = P_START;
      route.delete();
      m_ret = 0;
    end else if (m_ph == P_START) begin
      m_ph = P_FETCH;
    end else if ((m_ph == P_FETCH || m_ph == P_MEMRD || m_ph == P_MEMWR) && !mem_ready) begin
      m_ph = m_ph;
    end else if (m_ph == P_FETCH) begin
      m_ph = P_DECODE;
    end else if (m_ph == P_DECODE) begin
      case (OP)
        I_LW:    route = '{P_MEMADR, P_MEMRD, P_MEMWB};
        I_SW:    route = '{P_MEMADR, P_MEMWR};
        I_RT:    route = '{P_EXEC, P_ALUWB};
        I_BEQ:   route = '{P_BRANCH};
        I_ADDI:  route = '{P_ADDIEX, P_ADDIWB};
        I_J:     route = '{P_JUMP};
        default: route.delete();
      endcase
      if (route.size() == 0) m_ph = P_FETCH;
      else m_ph = route.pop_front();
    end else if (route.size() == 0) begin
      m_ret = (m_ret + 1) % (1 << CNT_W);
      m_ph  = P_FETCH;
    end else begin
      m_ph = route.pop_front();
    end
  end

  // Per-cycle comparison plus pulse counters for the directed checks
  int ir_cnt = 0, pc_cnt = 0, dm_cnt = 0, reg_cnt = 0, ill_cnt = 0, mwb_cnt = 0;
  always @(negedge clk) begin
    logic [15:0] exp_vec;
    exp_vec = model_out(m_ph, mem_ready, zero, OP);
    checks++;
    if (dut_vec !== exp_vec) begin
      errors++;
      $display("FAIL ctrl_vec t=%0t phase=%0d got %h want %h", $time, m_ph, dut_vec, exp_vec);
    end
    checks++;
    if (retired !== CNT_W'(m_ret)) begin
      errors++;
      $display("FAIL retired_cycle t=%0t got %0d want %0d", $time, retired, m_ret);
    end
    if (IR_WE === 1'b1) ir_cnt++;
    if (PC_WE === 1'b1) pc_cnt++;
    if (DM_WE === 1'b1) dm_cnt++;
    if (Reg_WE === 1'b1) reg_cnt++;
    if (illegal === 1'b1) ill_cnt++;
    if (Reg_WE === 1'b1 && MEM_to_REG === 1'b1) mwb_cnt++;
  end

  // ---------------- directed stimulus ----------------
  int exp_ret = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH: nf not-ready cycles in FETCH, nm in MEMRD/MEMWR
  task automatic run_instr(input string name, input logic [5:0] op, input logic z,
                           input int nf, input int nm, input int ncyc, input int rdelta);
    OP = op;
    zero = z;
    for (int c = 0; c < ncyc; c++) begin
      mem_ready = !((c < nf) || (c >= nf + 3 && c < nf + 3 + nm));
      if (c == ncyc - 1) chk({name, "_ret_before_last"}, int'(retired), exp_ret);
      cyc();
    end
    exp_ret = (exp_ret + rdelta) % (1 << CNT_W);
    chk({name, "_retired"}, int'(retired), exp_ret);
    chk({name, "_model_ret"}, m_ret, exp_ret);
  endtask

  initial begin
    int ir0, pc0, dm0, reg0, ill0, mwb0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("start_outputs", int'(dut_vec), 0);
    chk("start_retired", int'(retired), 0);
    mem_ready = 1'b1;
    cyc();
    chk("fetch_mem_req", int'(mem_req), 1);

    run_instr("rtype", I_RT, 1'b0, 0, 0, 4, 1);

    ir0 = ir_cnt; mwb0 = mwb_cnt;
    run_instr("lw_stall", I_LW, 1'b0, 2, 3, 10, 1);
    chk("lw_ir_we_pulses", ir_cnt - ir0, 1);
    chk("lw_memwb_cycles", mwb_cnt - mwb0, 1);

    pc0 = pc_cnt;
    run_instr("beq_taken", I_BEQ, 1'b1, 0, 0, 3, 1);
    chk("beq_taken_pc_we", pc_cnt - pc0, 2);
    pc0 = pc_cnt;
    run_instr("beq_not", I_BEQ, 1'b0, 0, 0, 3, 1);
    chk("beq_not_pc_we", pc_cnt - pc0, 1);

    dm0 = dm_cnt; reg0 = reg_cnt;
    run_instr("sw_stall", I_SW, 1'b0, 0, 1, 5, 1);
    chk("sw_dm_we_cycles", dm_cnt - dm0, 1);
    chk("sw_reg_we_cycles", reg_cnt - reg0, 0);

    run_instr("addi", I_ADDI, 1'b0, 0, 0, 4, 1);
    run_instr("lw_fast", I_LW, 1'b0, 0, 0, 5, 1);
    run_instr("sw_fast", I_SW, 1'b0, 0, 0, 4, 1);

    ill0 = ill_cnt;
    run_instr("illegal_op", I_BAD, 1'b0, 0, 0, 2, 0);
    chk("illegal_pulses", ill_cnt - ill0, 1);
    chk("after_illegal_fetch", int'(mem_req), 1);
    chk("retired_before_reset", int'(retired), 8);

    // Reset in the middle of a stalled data read
    OP = I_LW;
    for (int c = 0; c < 5; c++) begin
      mem_ready = (c < 3);
      cyc();
    end
    chk("pre_reset_memrd_iord", int'(IorD), 1);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", int'(dut_vec), 0);
    chk("midreset_retired", int'(retired), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_ret = 0;
    mem_ready = 1'b1;
    chk("post_reset_start", int'(mem_req), 0);
    cyc();
    chk("post_reset_fetch", int'(mem_req), 1);

    // Counter wrap with back-to-back jumps
    for (int k = 0; k < 15; k++) run_instr("jump", I_J, 1'b0, 0, 0, 3, 1);
    chk("retired_at_15", int'(retired), 15);
    run_instr("jump_wrap", I_J, 1'b0, 0, 0, 3, 1);
    chk("retired_wrapped", int'(retired), 0);

    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
